if_fetch_stage: RTL

//  Instruction-fetch stage plus IF/ID pipeline register for the 5-stage MIPS core.

---
 rtl/if_fetch_stage.sv | 137 +++++++++++++
 1 files changed

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register for the 5-stage MIPS core.
// Keeps the PC, runs a req/ack handshake with instruction memory (any latency,
// including same-cycle ack), buffers a returned word while ID is stalled, and
// redirects the PC on a taken branch with no delay slot.
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pc_write,
   input  logic        IFID_write,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        ready,
   output logic [31:0] IFID_instr,
   output logic [31:0] IFID_pc_plus4,
   output logic        IFID_valid,
   output logic [4:0]  IFID_rs,
   output logic [4:0]  IFID_rt
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic        req_q, req_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] hold_q, hold_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc4_q, pc4_d;
   logic        valid_q, valid_d;

   logic        ready_c;
   logic        adv;
   logic        pc_upd;
   logic [31:0] instr_src;
   logic [31:0] pc_plus4;

   // Instruction availability and source: live memory data in FETCH, buffer in HOLD
   always_comb begin
      ready_c   = 1'b0;
      instr_src = imem_rdata;
      case (state_q)
         S_FETCH: ready_c = imem_ack;
         S_HOLD: begin
            ready_c   = 1'b1;
            instr_src = hold_q;
         end
         default: ready_c = 1'b0;
      endcase
   end

   assign adv      = ready_c & IFID_write;
   assign pc_upd   = ready_c & pc_write;
   // Wraps modulo 2^32 naturally through the 32-bit result width.
   assign pc_plus4 = pc_q + 32'd4;

   // Next-state logic for the FSM, the PC, the hold buffer and the IF/ID register
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      hold_d  = hold_q;
      instr_d = instr_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;

      case (state_q)
         S_IDLE: state_d = S_FETCH;
         S_FETCH: begin
            if (adv) begin
               state_d = S_FETCH;
            end else if (imem_ack) begin
               // ID is stalled: park the word so the memory is not asked again.
               hold_d  = imem_rdata;
               state_d = S_HOLD;
            end
         end
         S_HOLD: begin
            if (adv) state_d = S_FETCH;
         end
         default: state_d = S_IDLE;
      endcase

      if (adv) begin
         // A taken branch squashes the instruction behind it (no delay slot).
         instr_d = branch_taken ? 32'd0 : instr_src;
         valid_d = ~branch_taken;
         pc4_d   = pc_plus4;
      end

      if (pc_upd) begin
         pc_d = branch_taken ? (branch_target & 32'hFFFF_FFFC) : pc_plus4;
      end
   end

   // The request is registered and follows the next state, so back-to-back
   // fetches keep it high without a gap cycle.
   assign req_d = (state_d == S_FETCH);

   // State registers; reset abandons any outstanding request immediately
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         req_q   <= 1'b0;
         pc_q    <= RESET_PC;
         hold_q  <= 32'd0;
         instr_q <= 32'd0;
         pc4_q   <= 32'd0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         pc_q    <= pc_d;
         hold_q  <= hold_d;
         instr_q <= instr_d;
         pc4_q   <= pc4_d;
         valid_q <= valid_d;
      end
   end

   assign imem_req      = req_q;
   assign imem_addr     = pc_q;
   assign ready         = ready_c;
   assign IFID_instr    = instr_q;
   assign IFID_pc_plus4 = pc4_q;
   assign IFID_valid    = valid_q;
   assign IFID_rs       = instr_q[25:21];
   assign IFID_rt       = instr_q[20:16];

endmodule
